// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline stage: occupancy-encoded state and control bit map.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   localparam int unsigned CTRL_REG_WRITE  = 0;
   localparam int unsigned CTRL_ALU_SRC    = 1;
   localparam int unsigned CTRL_MEM_READ   = 2;
   localparam int unsigned CTRL_MEM_WRITE  = 3;
   localparam int unsigned CTRL_MEM_TO_REG = 4;
   localparam int unsigned CTRL_BRANCH     = 5;
   localparam int unsigned CTRL_ALU_OP_LO  = 6;
   localparam int unsigned CTRL_ALU_OP_HI  = 7;

   // State encoding doubles as the number of held entries.
   function automatic logic [1:0] state_occ(input state_e s);
      return 2'(s);
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline payload register; clear zeroes only the side-effecting (kill) fields.
module pipe_slot #(
   parameter int unsigned DATA_W = 1,
   parameter int unsigned KILL_W = 1
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_load,
   input  logic              i_clear,
   input  logic [DATA_W-1:0] i_data,
   input  logic [KILL_W-1:0] i_kill,
   output logic [DATA_W-1:0] o_data,
   output logic [KILL_W-1:0] o_kill
);

   logic [DATA_W-1:0] data_q;
   logic [KILL_W-1:0] kill_q;

   // Load wins over clear; data fields keep their last value when cleared.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         data_q <= '0;
         kill_q <= '0;
      end else if (i_load) begin
         data_q <= i_data;
         kill_q <= i_kill;
      end else if (i_clear) begin
         kill_q <= '0;
      end
   end

   assign o_data = data_q;
   assign o_kill = kill_q;

endmodule

// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline register with optional two-entry skid buffer and flush.
module id_ex_skid_stage
   import pipe_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned RAW     = 5,
   parameter int unsigned CTRL_W  = 8,
   parameter int unsigned SKID_EN = 1
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_flush,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [XLEN-1:0]   i_pc,
   input  logic [XLEN-1:0]   i_instr,
   input  logic [XLEN-1:0]   i_rs1_data,
   input  logic [XLEN-1:0]   i_rs2_data,
   input  logic [XLEN-1:0]   i_imm,
   input  logic [RAW-1:0]    i_rs1,
   input  logic [RAW-1:0]    i_rs2,
   input  logic [RAW-1:0]    i_rd,
   input  logic [CTRL_W-1:0] i_ctrl,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [XLEN-1:0]   o_pc,
   output logic [XLEN-1:0]   o_instr,
   output logic [XLEN-1:0]   o_rs1_data,
   output logic [XLEN-1:0]   o_rs2_data,
   output logic [XLEN-1:0]   o_imm,
   output logic [RAW-1:0]    o_rs1,
   output logic [RAW-1:0]    o_rs2,
   output logic [RAW-1:0]    o_rd,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [1:0]        o_occupancy
);

   localparam int unsigned DATA_W = 5 * XLEN + 2 * RAW;
   localparam int unsigned KILL_W = RAW + CTRL_W;

   state_e            state_q, state_d;
   logic              valid_q;
   logic              in_fire, out_fire;
   logic              main_load, main_clear, main_src_skid;
   logic [DATA_W-1:0] in_data, skid_data, main_data;
   logic [KILL_W-1:0] in_kill, skid_kill, main_kill;

   assign in_fire  = i_valid & o_ready & ~i_flush;
   assign out_fire = valid_q & i_ready;

   assign in_data = {i_pc, i_instr, i_rs1_data, i_rs2_data, i_imm, i_rs1, i_rs2};
   assign in_kill = {i_rd, i_ctrl};

   // Next state and main-slot control; flush kills everything and drops the input.
   always_comb begin
      state_d       = state_q;
      main_load     = 1'b0;
      main_clear    = 1'b0;
      main_src_skid = 1'b0;
      if (i_flush) begin
         state_d    = ST_EMPTY;
         main_clear = 1'b1;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d   = ST_ONE;
                  main_load = 1'b1;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_load = 1'b1;
               end else if (in_fire) begin
                  state_d = (SKID_EN != 0) ? ST_TWO : ST_ONE;
               end else if (out_fire) begin
                  state_d    = ST_EMPTY;
                  main_clear = 1'b1;
               end
            end
            ST_TWO: begin
               if (out_fire) begin
                  state_d       = ST_ONE;
                  main_load     = 1'b1;
                  main_src_skid = 1'b1;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_EMPTY;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= (state_d != ST_EMPTY);
      end
   end

   assign main_data = main_src_skid ? skid_data : in_data;
   assign main_kill = main_src_skid ? skid_kill : in_kill;

   pipe_slot #(.DATA_W(DATA_W), .KILL_W(KILL_W)) u_main (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (main_load),
      .i_clear (main_clear),
      .i_data  (main_data),
      .i_kill  (main_kill),
      .o_data  ({o_pc, o_instr, o_rs1_data, o_rs2_data, o_imm, o_rs1, o_rs2}),
      .o_kill  ({o_rd, o_ctrl})
   );

   if (SKID_EN != 0) begin : g_skid
      logic ready_q;
      logic skid_load, skid_clear;

      // Skid catches the input when main is full and EX stalls.
      assign skid_load  = ~i_flush & (state_q == ST_ONE) & in_fire & ~out_fire;
      assign skid_clear = i_flush | ((state_q == ST_TWO) & out_fire);

      // Ready is registered off next state, so i_ready never reaches o_ready.
      always_ff @(posedge i_clk) begin
         if (i_reset) ready_q <= 1'b0;
         else         ready_q <= (state_d != ST_TWO);
      end

      pipe_slot #(.DATA_W(DATA_W), .KILL_W(KILL_W)) u_skid (
         .i_clk   (i_clk),
         .i_reset (i_reset),
         .i_load  (skid_load),
         .i_clear (skid_clear),
         .i_data  (in_data),
         .i_kill  (in_kill),
         .o_data  (skid_data),
         .o_kill  (skid_kill)
      );

      assign o_ready = ready_q;
   end else begin : g_noskid
      assign skid_data = '0;
      assign skid_kill = '0;
      assign o_ready   = ~valid_q | i_ready;
   end

   assign o_valid     = valid_q;
   assign o_occupancy = state_occ(state_q);

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Directed bench for id_ex_skid_stage: skid instance plus a SKID_EN=0 instance.
module tb_id_ex_skid_stage;

   logic        i_clk = 1'b0;
   logic        i_reset, i_flush, i_valid, i_ready, i_valid0, i_ready0;
   logic [31:0] i_pc, i_instr, i_rs1_data, i_rs2_data, i_imm;
   logic [4:0]  i_rs1, i_rs2, i_rd;
   logic [7:0]  i_ctrl;

   logic        o_ready, o_valid;
   logic [31:0] o_pc, o_instr, o_rs1_data, o_rs2_data, o_imm;
   logic [4:0]  o_rs1, o_rs2, o_rd;
   logic [7:0]  o_ctrl;
   logic [1:0]  o_occupancy;

   logic        o_ready0, o_valid0;
   logic [31:0] o_pc0, o_instr0, o_rs1_data0, o_rs2_data0, o_imm0;
   logic [4:0]  o_rs1_0, o_rs2_0, o_rd0;
   logic [7:0]  o_ctrl0;
   logic [1:0]  o_occupancy0;

   int checks   = 0;
   int failures = 0;

   always #5 i_clk = ~i_clk;

   id_ex_skid_stage #(.XLEN(32), .RAW(5), .CTRL_W(8), .SKID_EN(1)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
      .i_pc(i_pc), .i_instr(i_instr), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
      .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_ctrl(i_ctrl),
      .o_valid(o_valid), .i_ready(i_ready),
      .o_pc(o_pc), .o_instr(o_instr), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_imm(o_imm),
      .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_ctrl(o_ctrl), .o_occupancy(o_occupancy)
   );

   id_ex_skid_stage #(.XLEN(32), .RAW(5), .CTRL_W(8), .SKID_EN(0)) dut0 (
      .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid0), .o_ready(o_ready0),
      .i_pc(i_pc), .i_instr(i_instr), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
      .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_ctrl(i_ctrl),
      .o_valid(o_valid0), .i_ready(i_ready0),
      .o_pc(o_pc0), .o_instr(o_instr0), .o_rs1_data(o_rs1_data0), .o_rs2_data(o_rs2_data0), .o_imm(o_imm0),
      .o_rs1(o_rs1_0), .o_rs2(o_rs2_0), .o_rd(o_rd0), .o_ctrl(o_ctrl0), .o_occupancy(o_occupancy0)
   );

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_in(input logic [31:0] pc, input logic [7:0] ctrl, input logic [4:0] rd);
      i_pc       = pc;
      i_instr    = pc + 32'h1000_0000;
      i_rs1_data = ~pc;
      i_rs2_data = pc << 1;
      i_imm      = pc >> 2;
      i_rs1      = rd + 5'd1;
      i_rs2      = rd + 5'd2;
      i_rd       = rd;
      i_ctrl     = ctrl;
   endtask

   task automatic fill_two(input logic [31:0] base);
      i_ready = 1'b0;
      i_valid = 1'b1;
      set_in(base, 8'h21, 5'd5);
      step();
      set_in(base + 32'd4, 8'h22, 5'd6);
      step();
   endtask

   task automatic test_reset();
      i_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
      i_valid0 = 1'b0; i_ready0 = 1'b0;
      set_in(32'h0, 8'h0, 5'd0);
      step(); step();
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", o_valid); end
      checks++; if (o_occupancy !== 2'd0) begin failures++; $display("FAIL rst_occ got=%0d exp=0", o_occupancy); end
      checks++; if (o_pc !== 32'h0 || o_ctrl !== 8'h0 || o_rd !== 5'h0) begin failures++; $display("FAIL rst_payload pc=%h ctrl=%h rd=%h exp=0", o_pc, o_ctrl, o_rd); end
      checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b exp=0", o_ready); end
      i_reset = 1'b0;
      step();
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%0b exp=1", o_ready); end
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid_after got=%0b exp=0", o_valid); end
   endtask

   task automatic test_basic();
      set_in(32'h100, 8'h15, 5'd3);
      i_valid = 1'b1; i_ready = 1'b1;
      step();
      checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", o_valid); end
      checks++; if (o_pc !== 32'h100) begin failures++; $display("FAIL basic_pc got=%h exp=100", o_pc); end
      checks++; if (o_ctrl !== 8'h15) begin failures++; $display("FAIL basic_ctrl got=%h exp=15", o_ctrl); end
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%0b exp=1", o_ready); end
      checks++;
      if ({o_instr, o_rs1_data, o_rs2_data, o_imm, o_rs1, o_rs2, o_rd} !==
          {32'h1000_0100, 32'hFFFF_FEFF, 32'h200, 32'h40, 5'd4, 5'd5, 5'd3}) begin
         failures++; $display("FAIL basic_fields instr=%h rs1d=%h rs2d=%h imm=%h rs1=%0d rs2=%0d rd=%0d", o_instr, o_rs1_data, o_rs2_data, o_imm, o_rs1, o_rs2, o_rd);
      end
      i_valid = 1'b0;
      step();
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL bubble_valid got=%0b exp=0", o_valid); end
      checks++; if (o_ctrl !== 8'h0 || o_rd !== 5'h0) begin failures++; $display("FAIL bubble_kill ctrl=%h rd=%h exp=0", o_ctrl, o_rd); end
      checks++; if (o_pc !== 32'h100) begin failures++; $display("FAIL bubble_pc_hold got=%h exp=100", o_pc); end
   endtask

   task automatic test_skid();
      fill_two(32'h200);
      checks++; if (o_occupancy !== 2'd2) begin failures++; $display("FAIL skid_occ got=%0d exp=2", o_occupancy); end
      checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL skid_ready got=%0b exp=0", o_ready); end
      checks++; if (o_pc !== 32'h200 || o_valid !== 1'b1) begin failures++; $display("FAIL skid_head pc=%h v=%0b exp=200/1", o_pc, o_valid); end
      i_valid = 1'b0; i_ready = 1'b1;
      step();
      checks++; if (o_pc !== 32'h204 || o_ctrl !== 8'h22 || o_rd !== 5'd6) begin failures++; $display("FAIL skid_second pc=%h ctrl=%h rd=%0d exp=204/22/6", o_pc, o_ctrl, o_rd); end
      checks++; if (o_occupancy !== 2'd1 || o_ready !== 1'b1) begin failures++; $display("FAIL skid_drain occ=%0d rdy=%0b exp=1/1", o_occupancy, o_ready); end
      step();
      checks++; if (o_valid !== 1'b0 || o_occupancy !== 2'd0) begin failures++; $display("FAIL skid_empty v=%0b occ=%0d exp=0/0", o_valid, o_occupancy); end
   endtask

   task automatic test_flush();
      fill_two(32'h200);
      set_in(32'h208, 8'h33, 5'd7);
      i_valid = 1'b1; i_flush = 1'b1;
      step();
      i_flush = 1'b0; i_valid = 1'b0;
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", o_valid); end
      checks++; if (o_ctrl !== 8'h0 || o_rd !== 5'h0) begin failures++; $display("FAIL flush_kill ctrl=%h rd=%h exp=0", o_ctrl, o_rd); end
      checks++; if (o_occupancy !== 2'd0 || o_ready !== 1'b1) begin failures++; $display("FAIL flush_state occ=%0d rdy=%0b exp=0/1", o_occupancy, o_ready); end
      i_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL flush_ghost cyc=%0d pc=%h v=%0b exp_v=0", k, o_pc, o_valid); end
      end
      checks++; if (o_pc !== 32'h200) begin failures++; $display("FAIL flush_pc_hold got=%h exp=200", o_pc); end
   endtask

   task automatic test_back_to_back();
      int tx = 0;
      int rx = 0;
      int cyc = 0;
      while (cyc < 400 && rx < 16) begin
         i_valid = (tx < 16);
         set_in(32'(tx * 4), 8'(tx * 4 + 1), 5'(tx));
         i_ready = 1'($urandom_range(0, 1));
         #1;
         if (o_valid && i_ready) begin
            checks++;
            if (o_pc !== 32'(rx * 4) || o_ctrl !== 8'(rx * 4 + 1) || o_rd !== 5'(rx)) begin
               failures++; $display("FAIL b2b_order idx=%0d pc=%h ctrl=%h rd=%0d exp_pc=%h", rx, o_pc, o_ctrl, o_rd, 32'(rx * 4));
            end
            rx++;
         end
         if (i_valid && o_ready) tx++;
         step();
         cyc++;
      end
      checks++; if (rx != 16) begin failures++; $display("FAIL b2b_count got=%0d exp=16", rx); end
      i_valid = 1'b0; i_ready = 1'b1;
      step();
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL b2b_extra pc=%h v=%0b exp_v=0", o_pc, o_valid); end
   endtask

   task automatic test_no_skid();
      logic [15:0] pat;
      pat = 16'b1010_0110_0011_1001;
      set_in(32'h400, 8'h44, 5'd9);
      i_valid0 = 1'b1;
      for (int k = 0; k < 16; k++) begin
         i_ready0 = pat[k];
         #1;
         checks++; if (o_ready0 !== (~o_valid0 | i_ready0)) begin failures++; $display("FAIL noskid_ready cyc=%0d got=%0b exp=%0b", k, o_ready0, ~o_valid0 | i_ready0); end
         checks++; if (o_occupancy0 > 2'd1) begin failures++; $display("FAIL noskid_occ cyc=%0d got=%0d exp<=1", k, o_occupancy0); end
         step();
      end
      i_valid0 = 1'b0; i_ready0 = 1'b1;
      step();
      checks++; if (o_valid0 !== 1'b0 || o_ctrl0 !== 8'h0 || o_rd0 !== 5'h0) begin failures++; $display("FAIL noskid_bubble v=%0b ctrl=%h rd=%h exp=0", o_valid0, o_ctrl0, o_rd0); end
      checks++;
      if ({o_pc0, o_instr0, o_rs1_data0, o_rs2_data0, o_imm0, o_rs1_0, o_rs2_0} !==
          {32'h400, 32'h1000_0400, 32'hFFFF_FBFF, 32'h800, 32'h100, 5'd10, 5'd11}) begin
         failures++; $display("FAIL noskid_payload pc=%h instr=%h imm=%h", o_pc0, o_instr0, o_imm0);
      end
   endtask

   task automatic test_reset_mid();
      fill_two(32'h300);
      i_reset = 1'b1; i_flush = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
      step();
      checks++; if (o_valid !== 1'b0 || o_occupancy !== 2'd0) begin failures++; $display("FAIL rmid_state v=%0b occ=%0d exp=0/0", o_valid, o_occupancy); end
      checks++; if (o_pc !== 32'h0 || o_instr !== 32'h0 || o_ctrl !== 8'h0 || o_rd !== 5'h0) begin failures++; $display("FAIL rmid_zero pc=%h instr=%h ctrl=%h rd=%h exp=0", o_pc, o_instr, o_ctrl, o_rd); end
      checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL rmid_ready got=%0b exp=0", o_ready); end
      i_reset = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
      step();
      checks++; if (o_ready !== 1'b1 || o_occupancy !== 2'd0) begin failures++; $display("FAIL rmid_after rdy=%0b occ=%0d exp=1/0", o_ready, o_occupancy); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_skid();
      test_flush();
      test_back_to_back();
      test_no_skid();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_ex_skid_stage.md
ID_EX_SKID_STAGE -- requirements
Module: id_ex_skid_stage

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  XLEN  32  width of pc, instruction, operand and immediate fields
  RAW  5  register-address width (rs1/rs2/rd)
  CTRL_W  8  packed control-bundle width
  SKID_EN  1  1 = two-entry skid buffer with registered o_ready; 0 = single register, combinational o_ready
REQ-002 Ports (name  direction  width  meaning):
  i_clk  in  1  the block's only clock, rising edge
  i_reset  in  1  synchronous, active-high reset
  i_flush  in  1  kill every held entry (branch mispredict / trap)
  i_valid  in  1  upstream (ID) entry valid
  o_ready  out  1  stage can accept an entry
  i_pc, i_instr, i_rs1_data, i_rs2_data, i_imm  in  XLEN each  payload
  i_rs1, i_rs2, i_rd  in  RAW each  register addresses
  i_ctrl  in  CTRL_W  packed control bundle
  o_valid  out  1  downstream (EX) entry valid
  i_ready  in  1  EX can consume
  o_pc, o_instr, o_rs1_data, o_rs2_data, o_imm  out  XLEN each  registered payload
  o_rs1, o_rs2, o_rd  out  RAW each  registered addresses
  o_ctrl  out  CTRL_W  registered control bundle
  o_occupancy  out  2  entries held (0..2)
REQ-003 One clock; reset synchronous and active-high on i_reset; no other clock or asynchronous input.

Function
REQ-004 in_fire = i_valid & o_ready & !i_flush; out_fire = o_valid & i_ready.
REQ-005 States: EMPTY (occ 0), ONE (main full), TWO (main+skid full; SKID_EN=1 only).
REQ-006 EMPTY: in_fire -> ONE, input loaded into main; else stay.
REQ-007 ONE: in_fire & out_fire -> ONE, main reloaded from input; in_fire & !out_fire -> TWO, input into skid; !in_fire & out_fire -> EMPTY; neither -> hold.
REQ-008 TWO: out_fire -> ONE, skid moves to main same edge; else hold; o_ready=0 in TWO, so no input accepted.
REQ-009 SKID_EN=1: o_ready is a register output, 1 exactly when state != TWO; no combinational path from i_ready to o_ready.
REQ-010 SKID_EN=0: o_ready = !o_valid | i_ready (combinational); TWO unreachable; skid register not instantiated.
REQ-011 Outputs always reflect main register; latency input-to-output exactly 1 cycle when EX ready.
REQ-012 o_ctrl and o_rd SHALL be 0 whenever o_valid=0 (bubble cannot write register file or memory).
REQ-013 i_flush (highest priority after reset): next state EMPTY, o_valid=0, o_ctrl=0, o_rd=0, skid discarded; a coincident input handshake is dropped; coincident out_fire still counts as consumed.
REQ-014 Payload order preserved; no entry duplicated or lost except by i_flush.
REQ-015 Payload fields other than ctrl/rd hold their last value when invalid.

Reset
REQ-016 Synchronous i_reset SHALL zero every output register and skid entry, force EMPTY, o_occupancy=0, o_valid=0.
REQ-017 o_ready SHALL be 1 from the first edge after reset deasserts; inputs ignored while i_reset=1; reset overrides i_flush and in-flight handshakes.

Structure
REQ-018 Package pipe_pkg SHALL hold state encoding and ctrl bit positions: reg_write 0, alu_src 1, mem_read 2, mem_write 3, mem_to_reg 4, branch 5, alu_op 7:6.
REQ-019 Sub-module pipe_slot (one payload register with load and clear) SHALL be instantiated for main and, under SKID_EN=1, skid.

Verification
REQ-020 Reset then i_valid=1, pc=0x100, ctrl=0x15, i_ready=1 -> next cycle o_valid=1, o_pc=0x100, o_ctrl=0x15, o_ready=1.
REQ-021 SKID_EN=1, i_ready=0, two entries pc=0x200,0x204 -> occupancy 2, o_ready=0; i_ready=1 -> 0x200 then 0x204 out on consecutive cycles.
REQ-022 In TWO assert i_flush with i_valid=1 -> next cycle o_valid=0, o_ctrl=0, o_rd=0, occupancy 0, o_ready=1; 0x208 never appears.
REQ-023 Back-to-back stream 0x0..0x3C, i_ready random 50% -> output sequence identical, no gaps or duplicates.
REQ-024 SKID_EN=0, i_ready toggled -> o_ready equals !o_valid | i_ready each cycle, occupancy never exceeds 1.
REQ-025 i_reset mid-stream in TWO -> all outputs 0, occupancy 0 one edge later.
